// File: rtl/matmul_feed_sequencer.sv
// Operand buffer and skewed west/north edge feeder for an N x N systolic minifloat MAC array.
// Optional accumulator-clear state enabled by defining MATSEQ_AUTO_CLEAR_EN.
module matmul_feed_sequencer #(
  parameter int N        = 2,
  parameter int DATA_W   = 8,
  parameter int PASS_LAT = 2,
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_en,
  input  logic                ld_sel,
  input  logic [IDX_W-1:0]    ld_row,
  input  logic [IDX_W-1:0]    ld_col,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                feed_valid,
  output logic                acc_clr,
  output logic [N*DATA_W-1:0] a_row,
  output logic [N*DATA_W-1:0] b_col
);

  localparam int FEED_LEN  = N + (N - 1) * PASS_LAT;
  localparam int DRAIN_LEN = (N - 1) * PASS_LAT + PASS_LAT + 1;
  localparam int CNT_W     = $clog2(FEED_LEN + DRAIN_LEN);
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_LEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2
`ifdef MATSEQ_AUTO_CLEAR_EN
    , S_CLEAR = 2'd3
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [DATA_W-1:0] a_buf [N][N];
  logic [DATA_W-1:0] b_buf [N][N];
  logic [DATA_W-1:0] a_nxt [N][N];
  logic [DATA_W-1:0] b_nxt [N][N];

  logic                busy_d, done_d, feed_d;
  logic [N*DATA_W-1:0] a_row_d, b_col_d;

  // Buffer write is folded into a next-value view so that a load issued in the
  // start cycle is already visible to the first registered FEED output.
  always_comb begin
    a_nxt = a_buf;
    b_nxt = b_buf;
    if (state == S_IDLE && ld_en) begin
      if (ld_sel) b_nxt[ld_row][ld_col] = ld_data;
      else        a_nxt[ld_row][ld_col] = ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_buf <= '{default: '0};
      b_buf <= '{default: '0};
    end else begin
      a_buf <= a_nxt;
      b_buf <= b_nxt;
    end
  end

  // State and step counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef MATSEQ_AUTO_CLEAR_EN
          state_nxt = S_CLEAR;
`else
          state_nxt = S_FEED;
`endif
        end
      end
`ifdef MATSEQ_AUTO_CLEAR_EN
      S_CLEAR: state_nxt = S_FEED;
`endif
      S_FEED:  if (cnt == FEED_LAST)  state_nxt = S_DRAIN;
      S_DRAIN: if (cnt == DRAIN_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (state_nxt != state || state_nxt == S_IDLE) cnt_nxt = '0;
    else                                           cnt_nxt = cnt + 1'b1;
  end

  // Output decode from the upcoming state/step so every output is registered.
  always_comb begin
    a_row_d = '0;
    b_col_d = '0;
    busy_d  = (state_nxt != S_IDLE);
    feed_d  = (state_nxt == S_FEED);
    done_d  = (state == S_DRAIN) && (state_nxt == S_IDLE);
    if (state_nxt == S_FEED) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned c = 0; c < N; c++) begin
          if (int'(cnt_nxt) == int'(i) * PASS_LAT + int'(c)) begin
            a_row_d[i*DATA_W +: DATA_W] = a_nxt[i][c];
            b_col_d[i*DATA_W +: DATA_W] = b_nxt[c][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      feed_valid <= 1'b0;
      a_row      <= '0;
      b_col      <= '0;
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      feed_valid <= feed_d;
      a_row      <= a_row_d;
      b_col      <= b_col_d;
    end
  end

`ifdef MATSEQ_AUTO_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_clr <= 1'b0;
    else     acc_clr <= (state_nxt == S_CLEAR);
  end
`else
  assign acc_clr = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_feed_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a run-relative timing model.
module tb_matmul_feed_sequencer;

  localparam int N     = 2;
  localparam int DW    = 8;
  localparam int PL    = 2;
  localparam int IW    = 1;
  localparam int FEED  = N + (N - 1) * PL;
  localparam int DRAIN = (N - 1) * PL + PL + 1;
`ifdef MATSEQ_AUTO_CLEAR_EN
  localparam int CL = 1;
`else
  localparam int CL = 0;
`endif
  localparam int TOTAL = CL + FEED + DRAIN;

  logic clk = 1'b0;
  logic rst, ld_en, ld_sel, start;
  logic [IW-1:0] ld_row, ld_col;
  logic [DW-1:0] ld_data;
  logic busy, done, feed_valid, acc_clr;
  logic [N*DW-1:0] a_row, b_col;

  int n_checks = 0;
  int n_errors = 0;

  // Model: buffer contents plus cycles elapsed since the accepting edge (0 = quiet idle).
  logic [DW-1:0] m_a [N][N];
  logic [DW-1:0] m_b [N][N];
  int rel = 0;

  always #5 clk = ~clk;

  matmul_feed_sequencer #(.N(N), .DATA_W(DW), .PASS_LAT(PL)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_row(ld_row),
    .ld_col(ld_col), .ld_data(ld_data), .start(start), .busy(busy), .done(done),
    .feed_valid(feed_valid), .acc_clr(acc_clr), .a_row(a_row), .b_col(b_col)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rel = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        m_a[r][c] = '0;
        m_b[r][c] = '0;
      end
  endtask

  task automatic model_edge();
    bit idle;
    if (rst) begin
      model_reset();
    end else begin
      idle = (rel == 0) || (rel == TOTAL + 1);
      if (idle && ld_en) begin
        if (ld_sel) m_b[ld_row][ld_col] = ld_data;
        else        m_a[ld_row][ld_col] = ld_data;
      end
      if (idle && start)              rel = 1;
      else if (rel >= 1 && rel <= TOTAL) rel++;
      else                            rel = 0;
    end
  endtask

  function automatic bit m_feed();
    int t = rel - 1 - CL;
    return (rel >= 1) && (rel <= TOTAL) && (t >= 0) && (t < FEED);
  endfunction

  function automatic logic [N*DW-1:0] exp_a();
    logic [N*DW-1:0] v = '0;
    int t = rel - 1 - CL;
    if (m_feed())
      for (int i = 0; i < N; i++) begin
        int k = t - i * PL;
        if (k >= 0 && k < N) v[i*DW +: DW] = m_a[i][k];
      end
    return v;
  endfunction

  function automatic logic [N*DW-1:0] exp_b();
    logic [N*DW-1:0] v = '0;
    int t = rel - 1 - CL;
    if (m_feed())
      for (int j = 0; j < N; j++) begin
        int k = t - j * PL;
        if (k >= 0 && k < N) v[j*DW +: DW] = m_b[k][j];
      end
    return v;
  endfunction

  task automatic compare_all();
    check("busy",       64'(busy),       64'(rel >= 1 && rel <= TOTAL));
    check("done",       64'(done),       64'(rel == TOTAL + 1));
    check("feed_valid", 64'(feed_valid), 64'(m_feed()));
    check("acc_clr",    64'(acc_clr),    64'(CL == 1 && rel == 1));
    check("a_row",      64'(a_row),      64'(exp_a()));
    check("b_col",      64'(b_col),      64'(exp_b()));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_ld(input bit en, input bit sel, input int r, input int c, input logic [DW-1:0] d);
    ld_en   = en;
    ld_sel  = sel;
    ld_row  = IW'(r);
    ld_col  = IW'(c);
    ld_data = d;
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    check("arst_busy",  64'(busy),       64'(0));
    check("arst_done",  64'(done),       64'(0));
    check("arst_feed",  64'(feed_valid), 64'(0));
    check("arst_clr",   64'(acc_clr),    64'(0));
    check("arst_a_row", 64'(a_row),      64'(0));
    check("arst_b_col", 64'(b_col),      64'(0));
    model_reset();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] av [4] = '{8'h11, 8'h12, 8'h13, 8'h14};
    logic [DW-1:0] bv [4] = '{8'h21, 8'h22, 8'h23, 8'h24};
    logic [N*DW-1:0] ea [4] = '{16'h0011, 16'h0012, 16'h1300, 16'h1400};
    logic [N*DW-1:0] eb [4] = '{16'h0021, 16'h0023, 16'h2200, 16'h2400};

    rst = 1'b1; start = 1'b0;
    set_ld(0, 0, 0, 0, '0);
    model_reset();
    step();
    step();
    rst = 1'b0;
    step();

    // Scenario 1/2: known matrices, explicit skew and handshake timing.
    for (int e = 0; e < 4; e++) begin
      set_ld(1, 0, e / 2, e % 2, av[e]); step();
      set_ld(1, 1, e / 2, e % 2, bv[e]); step();
    end
    set_ld(0, 0, 0, 0, '0);
    start = 1'b1; step(); start = 1'b0;
    check("s2_busy_c1", 64'(busy), 64'(1));
    check("s2_clr_c1",  64'(acc_clr), 64'(CL));
    if (CL == 1) step();
    for (int t = 0; t < FEED; t++) begin
      check("s1_a_row", 64'(a_row), 64'(ea[t]));
      check("s1_b_col", 64'(b_col), 64'(eb[t]));
      // Scenario 3: loads while busy must not land.
      set_ld(1, t % 2, t / 2, t % 2, 8'h7F);
      step();
    end
    set_ld(0, 0, 0, 0, '0);
    for (int d = 0; d < DRAIN - 1; d++) step();
    check("s2_busy_last", 64'(busy), 64'(1));
    step();
    check("s2_done",      64'(done), 64'(1));
    check("s2_busy_done", 64'(busy), 64'(0));
    step();
    check("s2_done_once", 64'(done), 64'(0));

    start = 1'b1; step(); start = 1'b0;
    if (CL == 1) step();
    check("s3_orig_a", 64'(a_row), 64'(16'h0011));
    check("s3_orig_b", 64'(b_col), 64'(16'h0021));
    for (int k = 0; k < TOTAL + 2; k++) step();

    // Scenario 4: start held high gives back-to-back runs.
    start = 1'b1;
    for (int k = 0; k < 3 * (TOTAL + 1) + 2; k++) step();
    start = 1'b0;
    for (int k = 0; k < TOTAL + 2; k++) step();

    // Scenario 5: reset at FEED t=2, then a run over cleared buffers.
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < CL + 2; k++) step();
    check("s5_pre_feed", 64'(feed_valid), 64'(1));
    async_reset();
    for (int k = 0; k < TOTAL + 3; k++) step();
    start = 1'b1; step(); start = 1'b0;
    if (CL == 1) step();
    check("s5_zero_a", 64'(a_row), 64'(0));
    for (int k = 0; k < TOTAL + 2; k++) step();

    // Scenario 6: load and start in the same cycle.
    set_ld(1, 0, 0, 0, 8'h5A);
    start = 1'b1; step(); start = 1'b0;
    set_ld(0, 0, 0, 0, '0);
    if (CL == 1) step();
    check("s6_a00", 64'(a_row[7:0]), 64'(8'h5A));
    for (int k = 0; k < TOTAL + 2; k++) step();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      set_ld($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, N - 1),
             $urandom_range(0, N - 1), DW'($urandom));
      start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 249) == 0) async_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
